// File: rtl/debug_dtm_hs.sv
// JTAG Debug Transport Module: IEEE 1149.1 TAP with IDCODE/DTMCS/DMI/BYPASS
// registers, bridging DMI scans to a valid/ready request and valid-only response channel.
module debug_dtm_hs #(
    parameter int unsigned ABITS        = 7,
    parameter int unsigned IR_LENGTH    = 5,
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001,
    parameter int unsigned IR_IDCODE    = 1,
    parameter int unsigned IR_DTMCS     = 'h10,
    parameter int unsigned IR_DMI       = 'h11,
    parameter int unsigned IDLE_HINT    = 0
) (
    input  logic             TCK,
    input  logic             TRST_N,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             TDO_OE,
    output logic             DMI_REQ_VALID,
    input  logic             DMI_REQ_READY,
    output logic [1:0]       DMI_REQ_OP,
    output logic [ABITS-1:0] DMI_REQ_AD,
    output logic [31:0]      DMI_REQ_DATA,
    input  logic             DMI_RSP_VALID,
    input  logic [1:0]       DMI_RSP_OP,
    input  logic [31:0]      DMI_RSP_DATA,
    output logic             DMI_HARDRESET,
    output logic [3:0]       o_tap_state
);

    localparam int unsigned DMI_W = ABITS + 34;

    typedef logic [IR_LENGTH-1:0] ir_t;

    localparam ir_t        L_IR_IDCODE  = ir_t'(IR_IDCODE);
    localparam ir_t        L_IR_DTMCS   = ir_t'(IR_DTMCS);
    localparam ir_t        L_IR_DMI     = ir_t'(IR_DMI);
    localparam ir_t        L_IR_CAPTURE = ir_t'(2'b01);
    localparam logic [5:0] L_ABITS      = 6'(ABITS);
    localparam logic [2:0] L_IDLE       = 3'(IDLE_HINT);

    typedef enum logic [3:0] {
        S_TLR    = 4'h0,
        S_IDLE   = 4'h1,
        S_SEL_DR = 4'h2,
        S_CAP_DR = 4'h3,
        S_SH_DR  = 4'h4,
        S_EX1_DR = 4'h5,
        S_PAU_DR = 4'h6,
        S_EX2_DR = 4'h7,
        S_UPD_DR = 4'h8,
        S_SEL_IR = 4'h9,
        S_CAP_IR = 4'hA,
        S_SH_IR  = 4'hB,
        S_EX1_IR = 4'hC,
        S_PAU_IR = 4'hD,
        S_EX2_IR = 4'hE,
        S_UPD_IR = 4'hF
    } tap_state_t;

    tap_state_t        r_state;
    tap_state_t        w_state_nx;

    ir_t               r_ir;
    ir_t               r_ir_sr;
    logic [31:0]       r_idcode_sr;
    logic [31:0]       r_dtmcs_sr;
    logic [DMI_W-1:0]  r_dmi_sr;
    logic              r_bypass;

    logic              r_busy;
    logic [1:0]        r_dmistat;
    logic              r_req_valid;
    logic [1:0]        r_req_op;
    logic [ABITS-1:0]  r_req_ad;
    logic [31:0]       r_req_data;
    logic [ABITS-1:0]  r_last_addr;
    logic [31:0]       r_last_data;
    logic              r_hardreset;
    logic              r_tdo;
    logic              r_tdo_oe;

    logic              w_sel_idcode;
    logic              w_sel_dtmcs;
    logic              w_sel_dmi;
    logic              w_sel_bypass;
    logic              w_upd_dmi;
    logic              w_upd_dtmcs;
    logic              w_cap_dmi;
    logic              w_hardreset;
    logic              w_dmireset;
    logic              w_rsp;
    logic              w_issue;
    logic              w_accept;
    logic              w_busy_eff;
    logic [1:0]        w_upd_op;
    logic [31:0]       w_upd_data;
    logic [ABITS-1:0]  w_upd_addr;
    logic [1:0]        w_dmistat_rsp;
    logic [1:0]        w_dmi_cap_op;
    logic [31:0]       w_last_data_nx;
    logic [31:0]       w_dtmcs_cap;
    logic              w_busy_nx;
    logic [1:0]        w_dmistat_nx;
    logic              w_req_valid_nx;
    logic              w_dr_tdo;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_state <= S_TLR;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_TLR:    w_state_nx = TMS ? S_TLR    : S_IDLE;
            S_IDLE:   w_state_nx = TMS ? S_SEL_DR : S_IDLE;
            S_SEL_DR: w_state_nx = TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_state_nx = TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_state_nx = TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_state_nx = TMS ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: w_state_nx = TMS ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: w_state_nx = TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_state_nx = TMS ? S_SEL_DR : S_IDLE;
            S_SEL_IR: w_state_nx = TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_state_nx = TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_state_nx = TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_state_nx = TMS ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: w_state_nx = TMS ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: w_state_nx = TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_state_nx = TMS ? S_SEL_DR : S_IDLE;
            default:  w_state_nx = S_TLR;
        endcase
    end

    assign w_sel_idcode = (r_ir == L_IR_IDCODE);
    assign w_sel_dtmcs  = (r_ir == L_IR_DTMCS);
    assign w_sel_dmi    = (r_ir == L_IR_DMI);
    assign w_sel_bypass = !(w_sel_idcode || w_sel_dtmcs || w_sel_dmi);

    assign w_upd_dmi   = (r_state == S_UPD_DR) && w_sel_dmi;
    assign w_upd_dtmcs = (r_state == S_UPD_DR) && w_sel_dtmcs;
    assign w_cap_dmi   = (r_state == S_CAP_DR) && w_sel_dmi;
    assign w_hardreset = w_upd_dtmcs && r_dtmcs_sr[17];
    assign w_dmireset  = w_upd_dtmcs && r_dtmcs_sr[16];

    assign w_upd_op   = r_dmi_sr[1:0];
    assign w_upd_data = r_dmi_sr[33:2];
    assign w_upd_addr = r_dmi_sr[DMI_W-1:34];

    // A response landing with dmihardreset belongs to the dropped transaction.
    assign w_rsp    = DMI_RSP_VALID && r_busy && !w_hardreset;
    assign w_accept = r_req_valid && DMI_REQ_READY;
    assign w_issue  = w_upd_dmi && (w_upd_op == 2'd1 || w_upd_op == 2'd2) &&
                      (r_dmistat == 2'd0) && !r_busy;

    // Capture sees the state after any response completing on the same edge.
    assign w_busy_eff     = r_busy && !w_rsp;
    assign w_dmistat_rsp  = (w_rsp && DMI_RSP_OP != 2'd0 && r_dmistat == 2'd0) ? 2'd2 : r_dmistat;
    assign w_last_data_nx = w_rsp ? DMI_RSP_DATA : r_last_data;
    assign w_dmi_cap_op   = w_busy_eff ? 2'd3 : w_dmistat_rsp;
    assign w_dtmcs_cap    = {14'b0, 2'b00, 1'b0, L_IDLE, r_dmistat, L_ABITS, 4'h1};

    always_comb begin
        w_busy_nx      = r_busy;
        w_dmistat_nx   = w_dmistat_rsp;
        w_req_valid_nx = r_req_valid;
        if (w_hardreset) begin
            w_busy_nx = 1'b0;
        end else if (w_issue) begin
            w_busy_nx = 1'b1;
        end else if (w_rsp) begin
            w_busy_nx = 1'b0;
        end
        if (w_hardreset || w_dmireset) begin
            w_dmistat_nx = 2'd0;
        end else if ((w_cap_dmi && w_busy_eff) || (w_upd_dmi && r_busy)) begin
            w_dmistat_nx = 2'd3;
        end
        if (w_hardreset) begin
            w_req_valid_nx = 1'b0;
        end else if (w_issue) begin
            w_req_valid_nx = 1'b1;
        end else if (w_accept) begin
            w_req_valid_nx = 1'b0;
        end
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_ir        <= L_IR_IDCODE;
            r_ir_sr     <= '0;
            r_idcode_sr <= '0;
            r_dtmcs_sr  <= '0;
            r_dmi_sr    <= '0;
            r_bypass    <= 1'b0;
            r_busy      <= 1'b0;
            r_dmistat   <= 2'd0;
            r_req_valid <= 1'b0;
            r_req_op    <= 2'd0;
            r_req_ad    <= '0;
            r_req_data  <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
            r_hardreset <= 1'b0;
        end else if (r_state == S_TLR) begin
            r_ir        <= L_IR_IDCODE;
            r_ir_sr     <= '0;
            r_idcode_sr <= '0;
            r_dtmcs_sr  <= '0;
            r_dmi_sr    <= '0;
            r_bypass    <= 1'b0;
            r_busy      <= 1'b0;
            r_dmistat   <= 2'd0;
            r_req_valid <= 1'b0;
            r_req_op    <= 2'd0;
            r_req_ad    <= '0;
            r_req_data  <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
            r_hardreset <= 1'b0;
        end else begin
            r_hardreset <= w_hardreset;
            r_busy      <= w_busy_nx;
            r_dmistat   <= w_dmistat_nx;
            r_req_valid <= w_req_valid_nx;
            r_last_data <= w_last_data_nx;

            if (r_state == S_CAP_IR) begin
                r_ir_sr <= L_IR_CAPTURE;
            end else if (r_state == S_SH_IR) begin
                r_ir_sr <= {TDI, r_ir_sr[IR_LENGTH-1:1]};
            end
            if (r_state == S_UPD_IR) begin
                r_ir <= r_ir_sr;
            end

            if (r_state == S_CAP_DR) begin
                if (w_sel_idcode) r_idcode_sr <= IDCODE_VALUE;
                if (w_sel_dtmcs)  r_dtmcs_sr  <= w_dtmcs_cap;
                if (w_sel_dmi)    r_dmi_sr    <= {r_last_addr, w_last_data_nx, w_dmi_cap_op};
                if (w_sel_bypass) r_bypass    <= 1'b0;
            end else if (r_state == S_SH_DR) begin
                if (w_sel_idcode) r_idcode_sr <= {TDI, r_idcode_sr[31:1]};
                if (w_sel_dtmcs)  r_dtmcs_sr  <= {TDI, r_dtmcs_sr[31:1]};
                if (w_sel_dmi)    r_dmi_sr    <= {TDI, r_dmi_sr[DMI_W-1:1]};
                if (w_sel_bypass) r_bypass    <= TDI;
            end

            // Request fields only change on issue, so they hold while waiting for READY.
            if (w_issue) begin
                r_req_op    <= w_upd_op;
                r_req_ad    <= w_upd_addr;
                r_req_data  <= w_upd_data;
                r_last_addr <= w_upd_addr;
            end
        end
    end

    always_comb begin
        w_dr_tdo = r_bypass;
        if (w_sel_idcode) begin
            w_dr_tdo = r_idcode_sr[0];
        end else if (w_sel_dtmcs) begin
            w_dr_tdo = r_dtmcs_sr[0];
        end else if (w_sel_dmi) begin
            w_dr_tdo = r_dmi_sr[0];
        end
    end

    // TDO launches on the falling edge so the probe samples it on the next rising edge.
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
            if (r_state == S_SH_IR) begin
                r_tdo    <= r_ir_sr[0];
                r_tdo_oe <= 1'b1;
            end else if (r_state == S_SH_DR) begin
                r_tdo    <= w_dr_tdo;
                r_tdo_oe <= 1'b1;
            end
        end
    end

    assign TDO           = r_tdo;
    assign TDO_OE        = r_tdo_oe;
    assign DMI_REQ_VALID = r_req_valid;
    assign DMI_REQ_OP    = r_req_op;
    assign DMI_REQ_AD    = r_req_ad;
    assign DMI_REQ_DATA  = r_req_data;
    assign DMI_HARDRESET = r_hardreset;
    assign o_tap_state   = r_state;

endmodule

// File: doc/debug_dtm_hs.md
Name: debug_dtm_hs

Overview:
Parametrised JTAG Debug Transport Module (RISC-V Debug Spec 0.13 DTM). It bridges an external JTAG TAP to the Debug Module over a valid/ready request channel and a valid-only response channel, all clocked by TCK. It supersedes the fire-and-forget DMI strobes with:
- tracking of outstanding requests
- busy and error reporting through sticky dmistat
- dtmcs.dmireset and dtmcs.dmihardreset
- a configurable address width, IR length and idle hint.

Parameters:
ABITS, 7, DMI address width (1..32); reported in dtmcs.abits.
IR_LENGTH, 5, instruction register width (>=5).
IDCODE_VALUE, 32'h00000001, value captured by IDCODE; bit 0 must be 1.
IR_IDCODE, 1, IDCODE instruction code (also the reset IR value).
IR_DTMCS, 'h10, DTMCS instruction code.
IR_DMI, 'h11, DMI instruction code.
IDLE_HINT, 0, 3-bit value reported in dtmcs.idle.

Ports:
TCK  in  1  sole clock; TAP/registers on rising edge, TDO on falling edge
TRST_N  in  1  asynchronous active-low reset
TMS  in  1  TAP mode select
TDI  in  1  serial data in
TDO  out  1  serial data out
TDO_OE  out  1  high in Shift-IR/Shift-DR
DMI_REQ_VALID  out  1  request valid, held until accepted
DMI_REQ_READY  in  1  DM accepts when VALID&READY at rising TCK
DMI_REQ_OP  out  2  1=read, 2=write
DMI_REQ_AD  out  ABITS  address
DMI_REQ_DATA  out  32  write data
DMI_RSP_VALID  in  1  one-cycle response strobe
DMI_RSP_OP  in  2  0=ok, 2=failed (3 is treated as 2)
DMI_RSP_DATA  in  32  read data
DMI_HARDRESET  out  1  one-TCK pulse to the DM on dmihardreset

Behaviour:
Reset (TRST_N low, asynchronous) and Test-Logic-Reset state:
- State=TLR; IR=IR_IDCODE; all data registers cleared.
- busy=0, dmistat=0, DMI_REQ_VALID=0, DMI_HARDRESET=0.
- TDO=0, TDO_OE=0, last response data=0, last address=0.

TAP state machine:
- The 16 IEEE 1149.1 states, with standard TMS transitions on rising TCK.
- Capture-IR loads {0..,2'b01}. IR shifts LSB first. Update-IR latches the IR.
- Any IR value other than IDCODE, DTMCS or DMI selects the 1-bit BYPASS register, which captures 0.
- TDO is registered on falling TCK from the selected register's bit 0.

DTMCS (32 bits):
- Capture loads {14'b0, 2'b00, 1'b0, IDLE_HINT, dmistat, ABITS[5:0], 4'h1}.
- Update-DR:
  - If bit16 is set: dmistat <= 0.
  - If bit17 is set: busy <= 0, DMI_REQ_VALID <= 0, dmistat <= 0, and DMI_HARDRESET pulses for one cycle. Any later response for the dropped transaction is ignored.

DMI register (ABITS+34 bits, {addr, data[31:0], op[1:0]}):
- Capture:
  - addr = last address.
  - data = last response data.
  - op = 3 if busy; otherwise op = dmistat.
  - If busy at capture: dmistat <= 3 (sticky).
- Update-DR, with op=1 or 2, dmistat=0 and busy=0:
  - Latch addr/data/op into the DMI_REQ_* outputs.
  - DMI_REQ_VALID <= 1 and busy <= 1, from the next rising edge.
- Update-DR with op=0, with dmistat≠0, or with busy=1: no request is issued. If busy=1, dmistat <= 3.

Request/response handshake:
- DMI_REQ_* outputs are held stable while VALID=1 and READY=0.
- VALID falls on the edge after it is accepted.
- busy is cleared by DMI_RSP_VALID, which may arrive in the same cycle as acceptance or later.
- On DMI_RSP_VALID:
  - Last response data <= DMI_RSP_DATA.
  - If DMI_RSP_OP≠0 and dmistat=0, dmistat <= 2.
- DMI_RSP_VALID while busy=0 is ignored.

Simultaneous events:
- Response and DMI Capture-DR on the same edge: the capture reflects the completed transaction (op=0 or 2, data=DMI_RSP_DATA), and dmistat is not set to 3.
- dmihardreset and a response on the same edge: the response is discarded.
- dmistat precedence: 3 beats 2. dmireset clears dmistat regardless of its current value.

Test Plan:
1. Reset, then IDCODE DR scan of 32 bits -> TDO shifts out IDCODE_VALUE LSB first; TDO_OE=1 only during Shift-DR.
2. DTMCS capture with ABITS=7, IDLE_HINT=5 -> scanned value 32'h00005071.
3. DMI write addr=0x10, data=0xDEADBEEF, READY held low 3 cycles -> REQ_VALID stays high with stable fields, drops the cycle after READY=1. Response op=0 then DMI scan -> op=0.
4. DMI read addr=0x04, response data=0x12345678 two cycles later, then DMI scan (op=0) -> captured data=0x12345678, op=0.
5. New DMI scan with no response pending -> op=3 captured, dtmcs.dmistat=3. A subsequent update is not issued. Response arrives, dmireset=1 -> dmistat=0, next request issues.
6. Response op=2 -> dmistat=2. Set dmihardreset while a request is outstanding -> DMI_HARDRESET single pulse, busy=0, late response ignored (captured data unchanged).
